// File: rtl/lcd_pkg.sv
// lcd_pkg: shared constants and types for the LCD rectangle-fill path.
//   - ST7789-style command bytes (CASET / RASET / RAMWR)
//   - DC bit values used in bit [8] of every 9-bit SPI word
//   - default panel geometry and pixel-counter width
//   - state encodings for the fill controller and the window-header sequencer
//   - par_word(): picks one of the four parameter bytes of a CASET/RASET window
package lcd_pkg;

    localparam logic [7:0] CMD_CASET = 8'h2A;
    localparam logic [7:0] CMD_RASET = 8'h2B;
    localparam logic [7:0] CMD_RAMWR = 8'h2C;

    localparam logic DC_CMD  = 1'b0;
    localparam logic DC_DATA = 1'b1;

    localparam int LCD_W_DEF = 240;
    localparam int LCD_H_DEF = 320;
    localparam int CNT_W_DEF = 17;

    // Fill controller: the header phase is one state here because the
    // CASET..RAMWR steps are sequenced inside lcd_win_seq.
    typedef enum logic [2:0] {
        FILL_IDLE,
        FILL_CHECK,
        FILL_HDR,
        FILL_PIX_HI,
        FILL_PIX_LO,
        FILL_DONE
    } fill_state_t;

    // Window-header sequencer: each state names the word currently outstanding.
    typedef enum logic [2:0] {
        HDR_IDLE,
        HDR_CASET,
        HDR_XPAR,
        HDR_RASET,
        HDR_YPAR,
        HDR_RAMWR
    } hdr_state_t;

    // Parameter bytes go out as start-hi, start-lo, end-hi, end-lo.
    function automatic logic [8:0] par_word(input logic [15:0] first_coord,
                                            input logic [15:0] last_coord,
                                            input logic [1:0]  idx);
        logic [7:0] b;
        case (idx)
            2'd0:    b = first_coord[15:8];
            2'd1:    b = first_coord[7:0];
            2'd2:    b = last_coord[15:8];
            default: b = last_coord[7:0];
        endcase
        return {DC_DATA, b};
    endfunction

endpackage

// File: rtl/lcd_fill_rect_if.sv
// lcd_fill_rect_if: request/handshake bundle between the string/number
// controller, lcd_fill_rect and the lcd_write SPI shifter.
//   fill_flag      start pulse (sampled only while not busy)
//   start_x/y      inclusive window top-left
//   end_x/y        inclusive window bottom-right
//   color          RGB565 fill colour
//   wr_done        lcd_write: previous word fully shifted out
//   fill_data      [8]=DC, [7:0]=byte; stable until wr_done
//   en_write_fill  one-cycle word request to lcd_write
//   busy           fill in progress
//   fill_done      one-cycle completion pulse
// master = controller/bench side, slave = lcd_fill_rect.
interface lcd_fill_rect_if;
    logic        fill_flag;
    logic [8:0]  start_x;
    logic [8:0]  start_y;
    logic [8:0]  end_x;
    logic [8:0]  end_y;
    logic [15:0] color;
    logic        wr_done;
    logic [8:0]  fill_data;
    logic        en_write_fill;
    logic        busy;
    logic        fill_done;

    modport master (
        output fill_flag, start_x, start_y, end_x, end_y, color, wr_done,
        input  fill_data, en_write_fill, busy, fill_done
    );

    modport slave (
        input  fill_flag, start_x, start_y, end_x, end_y, color, wr_done,
        output fill_data, en_write_fill, busy, fill_done
    );
endinterface

// File: rtl/lcd_win_seq.sv
// lcd_win_seq: emits the 11-word address-window header
//   CASET, xs_hi, xs_lo, xe_hi, xe_lo, RASET, ys_hi, ys_lo, ye_hi, ye_lo, RAMWR
// using the lcd_write request/wr_done handshake. Reusable by lcd_show_char.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   start             one-cycle pulse; coordinates must be stable from then on
//   x_start..y_end    inclusive window corners (zero-extended to 16 bits)
//   wr_done           lcd_write word-complete pulse
//   hdr_word          current 9-bit word, changes only when hdr_en pulses
//   hdr_en            one-cycle request per word
//   hdr_last          combinational: wr_done accepted for the RAMWR word,
//                     so the caller may issue its first data word next cycle
module lcd_win_seq
    import lcd_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [8:0] x_start,
    input  logic [8:0] x_end,
    input  logic [8:0] y_start,
    input  logic [8:0] y_end,
    input  logic       wr_done,
    output logic [8:0] hdr_word,
    output logic       hdr_en,
    output logic       hdr_last
);

    hdr_state_t state, next_state;
    logic [1:0] par_cnt, par_cnt_next;
    logic       advance;
    logic       load;
    logic [8:0] next_word;
    logic [15:0] xs16, xe16, ys16, ye16;

    assign xs16 = {7'd0, x_start};
    assign xe16 = {7'd0, x_end};
    assign ys16 = {7'd0, y_start};
    assign ye16 = {7'd0, y_end};

    // Outside idle exactly one word is always outstanding, so wr_done in any
    // active state completes it; wr_done in idle is ignored.
    assign advance = (state != HDR_IDLE) && wr_done;

    always_ff @(posedge clk) begin
        if (rst) state <= HDR_IDLE;
        else     state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            HDR_IDLE:  if (start) next_state = HDR_CASET;
            HDR_CASET: if (wr_done) next_state = HDR_XPAR;
            HDR_XPAR:  if (wr_done && par_cnt == 2'd3) next_state = HDR_RASET;
            HDR_RASET: if (wr_done) next_state = HDR_YPAR;
            HDR_YPAR:  if (wr_done && par_cnt == 2'd3) next_state = HDR_RAMWR;
            HDR_RAMWR: if (wr_done) next_state = HDR_IDLE;
            default:   next_state = HDR_IDLE;
        endcase
    end

    // Word for the state being entered; the parameter index restarts at 0
    // whenever we are not already inside a parameter run.
    always_comb begin
        par_cnt_next = ((state == HDR_XPAR) || (state == HDR_YPAR)) ? par_cnt + 2'd1 : 2'd0;
        load         = ((state == HDR_IDLE) && start) || (advance && (state != HDR_RAMWR));
        hdr_last     = advance && (state == HDR_RAMWR);
        next_word    = 9'd0;
        case (next_state)
            HDR_CASET: next_word = {DC_CMD, CMD_CASET};
            HDR_XPAR:  next_word = par_word(xs16, xe16, par_cnt_next);
            HDR_RASET: next_word = {DC_CMD, CMD_RASET};
            HDR_YPAR:  next_word = par_word(ys16, ye16, par_cnt_next);
            HDR_RAMWR: next_word = {DC_CMD, CMD_RAMWR};
            default:   next_word = 9'd0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hdr_word <= 9'd0;
            hdr_en   <= 1'b0;
            par_cnt  <= 2'd0;
        end else begin
            hdr_en <= load;
            if (load) begin
                hdr_word <= next_word;
                par_cnt  <= par_cnt_next;
            end
        end
    end

endmodule

// File: rtl/lcd_fill_rect.sv
// lcd_fill_rect: rectangle-fill generator for the 9-bit lcd_write word port.
// On an accepted fill_flag it checks the window, sends the CASET/RASET/RAMWR
// header via lcd_win_seq, then streams {color_hi, color_lo} once per pixel.
// Ports:
//   sys_clk   50 MHz clock
//   sys_rst   synchronous active-high reset; aborts a fill immediately
//   bus       lcd_fill_rect_if.slave (fill_flag, coords, color, wr_done in;
//             fill_data, en_write_fill, busy, fill_done out)
// Build option: LCD_FILL_CLAMP_EN clamps end_x/end_y to the panel edge when
// latched; otherwise any out-of-range coordinate rejects the fill.
module lcd_fill_rect
    import lcd_pkg::*;
#(
    parameter int LCD_W = LCD_W_DEF,
    parameter int LCD_H = LCD_H_DEF,
    parameter int CNT_W = CNT_W_DEF
)(
    input logic             sys_clk,
    input logic             sys_rst,
    lcd_fill_rect_if.slave  bus
);

    localparam logic [8:0]       X_MAX = 9'(LCD_W - 1);
    localparam logic [8:0]       Y_MAX = 9'(LCD_H - 1);
    localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);

    fill_state_t state, next_state;

    logic [8:0]       xs, ys, xe, ye;
    logic [8:0]       end_x_eff, end_y_eff;
    logic [15:0]      color_q;
    logic [CNT_W-1:0] pix_cnt, pix_total, w_len, h_len;
    logic             accept, win_ok;
    logic             hdr_start, hdr_en, hdr_last;
    logic [8:0]       hdr_word;
    logic             pix_load, pix_en;
    logic [8:0]       pix_word, pix_next;
    logic             busy_int, done_int;

`ifdef LCD_FILL_CLAMP_EN
    assign end_x_eff = (bus.end_x > X_MAX) ? X_MAX : bus.end_x;
    assign end_y_eff = (bus.end_y > Y_MAX) ? Y_MAX : bus.end_y;
`else
    assign end_x_eff = bus.end_x;
    assign end_y_eff = bus.end_y;
`endif

    assign accept = (state == FILL_IDLE) && bus.fill_flag;

    // start <= end <= max also keeps start in range.
    assign win_ok    = (xs <= xe) && (ys <= ye) && (xe <= X_MAX) && (ye <= Y_MAX);
    assign w_len     = CNT_W'(xe - xs) + ONE;
    assign h_len     = CNT_W'(ye - ys) + ONE;
    assign pix_total = w_len * h_len;

    lcd_win_seq u_win_seq (
        .clk      (sys_clk),
        .rst      (sys_rst),
        .start    (hdr_start),
        .x_start  (xs),
        .x_end    (xe),
        .y_start  (ys),
        .y_end    (ye),
        .wr_done  (bus.wr_done),
        .hdr_word (hdr_word),
        .hdr_en   (hdr_en),
        .hdr_last (hdr_last)
    );

    always_ff @(posedge sys_clk) begin
        if (sys_rst) state <= FILL_IDLE;
        else         state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            FILL_IDLE:   if (bus.fill_flag) next_state = FILL_CHECK;
            FILL_CHECK:  next_state = win_ok ? FILL_HDR : FILL_DONE;
            FILL_HDR:    if (hdr_last) next_state = FILL_PIX_HI;
            FILL_PIX_HI: if (bus.wr_done) next_state = FILL_PIX_LO;
            FILL_PIX_LO: if (bus.wr_done) next_state = (pix_cnt == ONE) ? FILL_DONE : FILL_PIX_HI;
            FILL_DONE:   next_state = FILL_IDLE;
            default:     next_state = FILL_IDLE;
        endcase
    end

    // The pixel word is queued on the same edge that completes the previous
    // word, so its request lands the cycle after wr_done.
    always_comb begin
        busy_int  = (state != FILL_IDLE) && (state != FILL_DONE);
        done_int  = (state == FILL_DONE);
        hdr_start = (state == FILL_CHECK) && win_ok;
        pix_load  = ((state == FILL_HDR) && hdr_last)
                 || ((state == FILL_PIX_HI) && bus.wr_done)
                 || ((state == FILL_PIX_LO) && bus.wr_done && (pix_cnt != ONE));
        pix_next  = (state == FILL_PIX_HI) ? {DC_DATA, color_q[7:0]} : {DC_DATA, color_q[15:8]};
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            xs       <= 9'd0;
            ys       <= 9'd0;
            xe       <= 9'd0;
            ye       <= 9'd0;
            color_q  <= 16'd0;
            pix_cnt  <= '0;
            pix_word <= 9'd0;
            pix_en   <= 1'b0;
        end else begin
            if (accept) begin
                xs      <= bus.start_x;
                ys      <= bus.start_y;
                xe      <= end_x_eff;
                ye      <= end_y_eff;
                color_q <= bus.color;
            end
            if (state == FILL_CHECK)
                pix_cnt <= pix_total;
            else if ((state == FILL_PIX_LO) && bus.wr_done)
                pix_cnt <= pix_cnt - ONE;
            pix_en <= pix_load;
            if (pix_load)
                pix_word <= pix_next;
        end
    end

    // Header words own the bus only during the header phase; otherwise the
    // last pixel word is held so fill_data moves only with a request.
    assign bus.fill_data     = (state == FILL_HDR) ? hdr_word : pix_word;
    assign bus.en_write_fill = hdr_en | pix_en;
    assign bus.busy          = busy_int;
    assign bus.fill_done     = done_int;

endmodule
